sccb_responder: RTL and testbench



---
 rtl/sccb_pkg.sv | 22 ++
 rtl/sccb_line_sync.sv | 44 ++++
 rtl/sccb_responder.sv | 177 +++++++++++++++++
 tb/tb_sccb_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder: FSM state encoding,
// R/W bit meaning and the default device ID.
package sccb_pkg;

    localparam logic [6:0] DEFAULT_DEV_ID = 7'h21;
    localparam logic       SCCB_WRITE     = 1'b0;
    localparam logic       SCCB_READ      = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_NA,
        IGNORE
    } sccb_state_t;

endpackage

// File: rtl/sccb_line_sync.sv
// Brings SCL/SDA into the clk domain and derives single-cycle edge,
// START and STOP pulses from the last two synchronized samples.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // Top bit of each pipe holds the previous synchronized sample.
    logic [SYNC_STAGES:0] scl_pipe_reg;
    logic [SYNC_STAGES:0] sda_pipe_reg;
    logic                 scl_s;
    logic                 scl_p;
    logic                 sda_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_pipe_reg <= '1;
            sda_pipe_reg <= '1;
        end else begin
            scl_pipe_reg <= {scl_pipe_reg[SYNC_STAGES-1:0], scl};
            sda_pipe_reg <= {sda_pipe_reg[SYNC_STAGES-1:0], sda_i};
        end
    end

    assign scl_s    = scl_pipe_reg[SYNC_STAGES-1];
    assign scl_p    = scl_pipe_reg[SYNC_STAGES];
    assign sda_s    = sda_pipe_reg[SYNC_STAGES-1];
    assign sda_p    = sda_pipe_reg[SYNC_STAGES];

    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start    = scl_s & scl_p & sda_p & ~sda_s;
    assign stop     = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave register responder: decodes ID/sub-address/data bytes from an
// oversampled bus and exposes a strobe-based external register port.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = DEFAULT_DEV_ID,
    parameter bit         ACK_EN      = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       txn_done
);

    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start;
    logic        stop;

    sccb_state_t state;
    logic [3:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic        ack_hold;
    logic        rd_pending;
    logic        rw_bit;
    logic [7:0]  rx_byte;

    sccb_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda_i   (sda_i),
        .sda_s   (sda_s),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    assign rx_byte = {rx_shift, sda_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            ack_hold   <= 1'b0;
            rd_pending <= 1'b0;
            rw_bit     <= SCCB_WRITE;
            sda_oe     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            busy       <= 1'b0;
            txn_done   <= 1'b0;
        end else begin
            reg_wr   <= 1'b0;
            reg_rd   <= 1'b0;
            txn_done <= 1'b0;

            // Read data arrives one cycle after the request strobe.
            if (rd_pending) begin
                tx_shift   <= reg_rdata;
                rd_pending <= 1'b0;
            end

            if (stop) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                ack_hold <= 1'b0;
                busy     <= 1'b0;
                txn_done <= busy;
            end else if (start) begin
                state    <= ID;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                ack_hold <= 1'b0;
            end else begin
                case (state)
                    ID, SUB, WDATA: begin
                        if (scl_rise) begin
                            rx_shift <= rx_byte[6:0];
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (state == ID) begin
                                    if (rx_byte[7:1] != DEV_ID) begin
                                        state <= IGNORE;
                                    end else begin
                                        busy   <= 1'b1;
                                        rw_bit <= rx_byte[0];
                                        state  <= ID_ACK;
                                        if (rx_byte[0] == SCCB_READ) begin
                                            reg_rd     <= 1'b1;
                                            rd_pending <= 1'b1;
                                        end
                                    end
                                end else if (state == SUB) begin
                                    reg_addr <= rx_byte;
                                    state    <= SUB_ACK;
                                end else begin
                                    reg_wdata <= rx_byte;
                                    reg_wr    <= 1'b1;
                                    state     <= WDATA_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // First fall opens the ACK slot, second fall closes it.
                    ID_ACK, SUB_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_hold) begin
                                ack_hold <= 1'b1;
                                sda_oe   <= ACK_EN;
                            end else begin
                                ack_hold <= 1'b0;
                                if (state == ID_ACK && rw_bit == SCCB_READ) begin
                                    state    <= RDATA;
                                    sda_oe   <= ~tx_shift[7];
                                    tx_shift <= {tx_shift[6:0], 1'b0};
                                    bit_cnt  <= 4'd1;
                                end else begin
                                    sda_oe <= 1'b0;
                                    if (state == ID_ACK)
                                        state <= SUB;
                                    else if (state == SUB_ACK)
                                        state <= WDATA;
                                    else
                                        state <= IGNORE;
                                end
                            end
                        end
                    end

                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RD_NA;
                            end else begin
                                sda_oe   <= ~tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    RD_NA: begin
                        if (scl_rise)
                            state <= IGNORE;
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Bit-banged SCCB master driving two responders (ACK enabled / disabled)
// against a register-file reference model with randomized transactions.
module tb_sccb_responder;

    localparam logic [6:0] DEV = 7'h21;
    localparam int         Q   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;

    logic       sda_oe, sda_oe_na;
    logic [7:0] reg_addr, reg_addr_na;
    logic [7:0] reg_wdata, reg_wdata_na;
    logic       reg_wr, reg_wr_na;
    logic       reg_rd, reg_rd_na;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] reg_rdata_na = 8'h00;
    logic       busy, busy_na;
    logic       txn_done, txn_done_na;

    assign sda_line = sda_m & ~sda_oe & ~sda_oe_na;

    always #5 clk = ~clk;

    sccb_responder #(.DEV_ID(DEV), .ACK_EN(1'b1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_line), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy), .txn_done(txn_done)
    );

    sccb_responder #(.DEV_ID(DEV), .ACK_EN(1'b0), .SYNC_STAGES(2)) dut_na (
        .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_line), .sda_oe(sda_oe_na),
        .reg_addr(reg_addr_na), .reg_wdata(reg_wdata_na), .reg_wr(reg_wr_na),
        .reg_rd(reg_rd_na), .reg_rdata(reg_rdata_na), .busy(busy_na),
        .txn_done(txn_done_na)
    );

    // External register storage seen by the DUTs (environment, not the model).
    logic [7:0] ext_mem [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (reg_wr) ext_mem[reg_addr] <= reg_wdata;
        reg_rdata    <= ext_mem[reg_addr];
        reg_rdata_na <= ext_mem[reg_addr_na];
    end

    // Cumulative event counters; transactions compare deltas.
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, busy_cyc = 0, both_cnt = 0;
    int wr_cnt_na = 0, rd_cnt_na = 0, done_cnt_na = 0;
    always @(negedge clk) begin
        if (reg_wr)              wr_cnt      <= wr_cnt + 1;
        if (reg_rd)              rd_cnt      <= rd_cnt + 1;
        if (txn_done)            done_cnt    <= done_cnt + 1;
        if (busy)                busy_cyc    <= busy_cyc + 1;
        if (reg_wr && reg_rd)    both_cnt    <= both_cnt + 1;
        if (reg_wr_na)           wr_cnt_na   <= wr_cnt_na + 1;
        if (reg_rd_na)           rd_cnt_na   <= rd_cnt_na + 1;
        if (txn_done_na)         done_cnt_na <= done_cnt_na + 1;
    end

    // Reference model: register contents plus the latched sub-address/data.
    logic [7:0] model_mem [256] = '{default: 8'h00};
    logic [7:0] model_addr  = 8'h00;
    logic [7:0] model_wdata = 8'h00;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic bit_slot(input logic b, output logic seen, output logic oe, output logic oe_na);
        sda_m = b;    wait_q();
        scl   = 1'b1; wait_q();
        seen  = sda_line;
        oe    = sda_oe;
        oe_na = sda_oe_na;
        wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic seen, oe, oe_na;
        for (int i = 7; i >= 0; i--) bit_slot(b[i], seen, oe, oe_na);
        bit_slot(1'b1, seen, oe, oe_na);
        check({tag, "_ack"}, oe, exp_ack);
        check({tag, "_ack_noack_build"}, oe_na, 1'b0);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic seen, oe, oe_na;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, seen, oe, oe_na);
            d[i] = seen;
        end
        bit_slot(1'b1, seen, oe, oe_na);
        check("na_slot_released", {oe, oe_na}, 2'b00);
    endtask

    // nb = 2 (sub only), 3 (sub + data), 4 (extra byte that must be ignored).
    task automatic txn_write(input logic [7:0] id, input logic [7:0] sub,
                             input logic [7:0] data, input int nb);
        logic matched;
        int wr0, rd0, dn0, by0, wn0, dn0_na;
        matched = (id[7:1] == DEV) && (id[0] == 1'b0);
        wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; by0 = busy_cyc;
        wn0 = wr_cnt_na; dn0_na = done_cnt_na;
        bus_start();
        send_byte(id, matched, "id");
        send_byte(sub, matched, "sub");
        if (nb >= 3) send_byte(data, matched, "data");
        if (nb >= 4) send_byte(~data, 1'b0, "extra");
        bus_stop();
        repeat (8) @(negedge clk);
        if (matched) begin
            model_addr = sub;
            if (nb >= 3) begin
                model_mem[sub] = data;
                model_wdata    = data;
            end
        end
        check("wr_count", wr_cnt - wr0, (matched && nb >= 3) ? 1 : 0);
        check("wr_count_noack_build", wr_cnt_na - wn0, (matched && nb >= 3) ? 1 : 0);
        check("rd_count", rd_cnt - rd0, 0);
        check("txn_done_count", done_cnt - dn0, matched ? 1 : 0);
        check("txn_done_noack_build", done_cnt_na - dn0_na, matched ? 1 : 0);
        check("busy_seen", (busy_cyc - by0) > 0, matched);
        check("busy_after_stop", busy, 1'b0);
        check("reg_addr", reg_addr, model_addr);
        check("reg_wdata", reg_wdata, model_wdata);
        check("reg_wdata_noack_build", reg_wdata_na, model_wdata);
        $display("txn write id=%02h sub=%02h data=%02h bytes=%0d", id, sub, data, nb);
    endtask

    task automatic txn_trunc(input logic [7:0] sub, input int nbits);
        logic seen, oe, oe_na;
        int wr0, dn0;
        wr0 = wr_cnt; dn0 = done_cnt;
        bus_start();
        send_byte({DEV, 1'b0}, 1'b1, "id");
        send_byte(sub, 1'b1, "sub");
        for (int i = 0; i < nbits; i++) bit_slot(1'($urandom_range(0, 1)), seen, oe, oe_na);
        bus_stop();
        repeat (8) @(negedge clk);
        model_addr = sub;
        check("trunc_no_wr", wr_cnt - wr0, 0);
        check("trunc_reg_addr", reg_addr, model_addr);
        check("trunc_txn_done", done_cnt - dn0, 1);
        check("trunc_idle", {busy, sda_oe}, 2'b00);
        $display("txn truncated-write sub=%02h data_bits=%0d", sub, nbits);
    endtask

    // mode 0: sub then STOP then read; 1: sub then repeated START read; 2: read only.
    task automatic txn_read(input logic [7:0] sub, input int mode);
        logic [7:0] d;
        int rd0, wr0, dn0, bt0;
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; bt0 = both_cnt;
        if (mode != 2) begin
            bus_start();
            send_byte({DEV, 1'b0}, 1'b1, "id");
            send_byte(sub, 1'b1, "sub");
            model_addr = sub;
            if (mode == 0) bus_stop();
        end
        bus_start();
        send_byte({DEV, 1'b1}, 1'b1, "rd_id");
        recv_byte(d);
        bus_stop();
        repeat (8) @(negedge clk);
        check("read_data", d, model_mem[model_addr]);
        check("rd_count", rd_cnt - rd0, 1);
        check("rd_count_noack_build", rd_cnt_na - rd0, 0 + (rd_cnt - rd0));
        check("wr_count_in_read", wr_cnt - wr0, 0);
        check("txn_done_count", done_cnt - dn0, (mode == 0) ? 2 : 1);
        check("reg_addr", reg_addr, model_addr);
        check("wr_rd_overlap", both_cnt - bt0, 0);
        $display("txn read sub=%02h mode=%0d data=%02h", model_addr, mode, d);
    endtask

    initial begin
        logic [6:0] r7;
        int kind;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_reg_wr", reg_wr, 1'b0);
        check("rst_reg_rd", reg_rd, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_txn_done", txn_done, 1'b0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Directed scenarios
        txn_write(8'h42, 8'h12, 8'h80, 3);
        txn_write(8'h42, 8'h1D, 8'h7F, 3);
        txn_read(8'h1D, 0);
        txn_write(8'h60, 8'h12, 8'h55, 3);
        txn_write(8'h42, 8'h44, 8'hA5, 4);
        txn_trunc(8'h1C, 4);
        txn_read(8'h1C, 2);
        txn_read(8'h1D, 1);

        // Reset while the responder is driving a zero read bit
        txn_write(8'h42, 8'h30, 8'h00, 3);
        bus_start();
        send_byte({DEV, 1'b1}, 1'b1, "rd_id");
        repeat (6) @(negedge clk);
        check("rd_driving_before_rst", sda_oe, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_release", {sda_oe, sda_oe_na}, 2'b00);
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_addr  = 8'h00;
        model_wdata = 8'h00;
        repeat (10) @(negedge clk);
        check("post_rst_reg_addr", reg_addr, 8'h00);
        check("post_rst_busy", busy, 1'b0);
        $display("txn reset during read data");
        txn_write(8'h42, 8'h31, 8'h5A, 3);
        txn_read(8'h31, 1);

        // Randomized mix
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: txn_write({DEV, 1'b0}, 8'($urandom), 8'($urandom), 3);
                1: begin
                    r7 = 7'($urandom);
                    if (r7 == DEV) r7 = r7 ^ 7'h01;
                    txn_write({r7, 1'($urandom_range(0, 1))}, 8'($urandom), 8'($urandom), 3);
                end
                2: txn_read(8'($urandom_range(0, 15)), $urandom_range(0, 2));
                3: txn_trunc(8'($urandom), $urandom_range(1, 7));
                default: txn_write({DEV, 1'b0}, 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(2, 4));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
